// File: rtl/str_byte_streamer_if.sv
// Handshake bundle for str_byte_streamer: packed-word input side and byte-stream output side.
interface str_byte_streamer_if #(
  parameter int WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_char;
  logic             out_last;
  logic             out_empty;

  // Producer/consumer side that drives words in and accepts bytes out.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_char, out_last, out_empty
  );

  // The streamer itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_char, out_last, out_empty
  );
endinterface

// File: rtl/str_byte_streamer.sv
// Streams a packed ASCII word as bytes, MSB first, optionally dropping leading NULs
// so the text matches what %s would display.
module str_byte_streamer #(
  parameter int WIDTH            = 128,
  parameter bit SKIP_LEADING_NUL = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  str_byte_streamer_if.slave bus
);
  localparam int NBYTES = WIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   word_reg, word_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               out_valid_reg, out_valid_next;
  logic [7:0]         out_char_reg, out_char_next;
  logic               out_last_reg, out_last_next;
  logic               out_empty_reg, out_empty_next;

  logic [7:0]         in_bytes   [NBYTES];
  logic [7:0]         word_bytes [NBYTES];
  logic [IDX_W-1:0]   nz_start;
  logic               any_nz;
  logic [IDX_W-1:0]   start_idx;
  logic [IDX_W-1:0]   idx_dec;
  logic               in_ready_int;
  logic               accept;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign in_bytes[gi]   = bus.in_data[gi*8 +: 8];
      assign word_bytes[gi] = word_reg[gi*8 +: 8];
    end
  endgenerate

  // Priority encoder: later (higher) non-zero bytes override earlier ones.
  always_comb begin
    nz_start = '0;
    any_nz   = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      if (in_bytes[i] != 8'h00) begin
        nz_start = IDX_W'(i);
        any_nz   = 1'b1;
      end
    end
  end

  assign start_idx    = SKIP_LEADING_NUL ? nz_start : IDX_W'(NBYTES - 1);
  assign idx_dec      = idx_reg - IDX_W'(1);
  assign in_ready_int = rst_n && (state_reg == IDLE);
  assign accept       = bus.in_valid && in_ready_int;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      word_reg      <= '0;
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_char_reg  <= 8'h00;
      out_last_reg  <= 1'b0;
      out_empty_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      word_reg      <= word_next;
      idx_reg       <= idx_next;
      out_valid_reg <= out_valid_next;
      out_char_reg  <= out_char_next;
      out_last_reg  <= out_last_next;
      out_empty_reg <= out_empty_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    word_next      = word_reg;
    idx_next       = idx_reg;
    out_valid_next = out_valid_reg;
    out_char_next  = out_char_reg;
    out_last_next  = out_last_reg;
    out_empty_next = out_empty_reg;
    case (state_reg)
      IDLE: begin
        out_valid_next = 1'b0;
        if (accept) begin
          state_next     = EMIT;
          word_next      = bus.in_data;
          idx_next       = start_idx;
          out_valid_next = 1'b1;
          out_char_next  = in_bytes[start_idx];
          out_last_next  = (start_idx == '0);
          out_empty_next = SKIP_LEADING_NUL && !any_nz;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (idx_reg == '0) begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
            out_empty_next = 1'b0;
          end else begin
            idx_next       = idx_dec;
            out_char_next  = word_bytes[idx_dec];
            out_last_next  = (idx_dec == '0);
            out_empty_next = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_char  = out_char_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.out_empty = out_empty_reg;
endmodule

// File: tb/tb_str_byte_streamer.sv
// Directed and randomized checks of str_byte_streamer against a byte-queue model,
// for both the NUL-skipping (u0) and full-width (u1) builds.
module tb_str_byte_streamer;
  logic         clk = 1'b0;
  logic         rst_n;
  int           sel;
  logic         drv_valid;
  logic [127:0] drv_data;
  logic         drv_ready;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_char [$];
  logic       exp_last [$];
  logic       exp_empty[$];

  str_byte_streamer_if #(.WIDTH(128)) ifc0 ();
  str_byte_streamer_if #(.WIDTH(128)) ifc1 ();

  str_byte_streamer #(.WIDTH(128), .SKIP_LEADING_NUL(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(ifc0)
  );
  str_byte_streamer #(.WIDTH(128), .SKIP_LEADING_NUL(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(ifc1)
  );

  always #5 clk = ~clk;

  assign ifc0.in_valid  = (sel == 0) && drv_valid;
  assign ifc0.in_data   = drv_data;
  assign ifc0.out_ready = (sel == 0) ? drv_ready : 1'b1;
  assign ifc1.in_valid  = (sel == 1) && drv_valid;
  assign ifc1.in_data   = drv_data;
  assign ifc1.out_ready = (sel == 1) ? drv_ready : 1'b1;

  logic       o_valid, o_last, o_empty, o_in_ready;
  logic [7:0] o_char;
  assign o_valid    = (sel == 1) ? ifc1.out_valid : ifc0.out_valid;
  assign o_char     = (sel == 1) ? ifc1.out_char  : ifc0.out_char;
  assign o_last     = (sel == 1) ? ifc1.out_last  : ifc0.out_last;
  assign o_empty    = (sel == 1) ? ifc1.out_empty : ifc0.out_empty;
  assign o_in_ready = (sel == 1) ? ifc1.in_ready  : ifc0.in_ready;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beats straight from the rules: find the first printable position, then
  // list every byte from there down to byte 0.
  task automatic build_model(input logic [127:0] w, input bit skip);
    int first;
    exp_char.delete();
    exp_last.delete();
    exp_empty.delete();
    first = -1;
    for (int i = 15; i >= 0; i--) begin
      if (first < 0 && w[i*8 +: 8] != 8'h00) first = i;
    end
    if (skip && first < 0) begin
      exp_char.push_back(8'h00);
      exp_last.push_back(1'b1);
      exp_empty.push_back(1'b1);
    end else begin
      if (!skip) first = 15;
      for (int i = first; i >= 0; i--) begin
        exp_char.push_back(w[i*8 +: 8]);
        exp_last.push_back(i == 0);
        exp_empty.push_back(1'b0);
      end
    end
  endtask

  task automatic send(input logic [127:0] w, input int stall_at, input int stall_len, input bit rnd);
    int n;
    int k;
    int cyc;
    int stall;
    bit stalled;
    build_model(w, sel == 0);
    n = 0;
    while (!o_in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", o_in_ready, 1);
    drv_data  = w;
    drv_valid = 1'b1;
    drv_ready = 1'b1;
    tick();
    drv_valid = 1'b0;
    drv_data  = {$urandom, $urandom, $urandom, $urandom};
    check("accept_latency_valid", o_valid, 1);
    check("in_ready_busy", o_in_ready, 0);
    k = 0;
    cyc = 0;
    stall = 0;
    stalled = 1'b0;
    while (k < exp_char.size() && cyc < 300) begin
      check($sformatf("valid[%0d]", k), o_valid, 1);
      check($sformatf("char[%0d]", k), o_char, exp_char[k]);
      check($sformatf("last[%0d]", k), o_last, exp_last[k]);
      check($sformatf("empty[%0d]", k), o_empty, exp_empty[k]);
      if (stall > 0) begin
        drv_ready = 1'b0;
        stall--;
      end else if (k == stall_at && !stalled) begin
        stalled   = 1'b1;
        stall     = stall_len - 1;
        drv_ready = 1'b0;
      end else if (rnd && $urandom_range(3) == 0) begin
        drv_ready = 1'b0;
      end else begin
        drv_ready = 1'b1;
        k++;
      end
      tick();
      cyc++;
    end
    check("all_beats_seen", k, exp_char.size());
    check("idle_out_valid", o_valid, 0);
    check("idle_in_ready", o_in_ready, 1);
  endtask

  initial begin
    logic [127:0] w;
    int lead;
    sel       = 0;
    rst_n     = 1'b0;
    drv_valid = 1'b1;
    drv_data  = 128'h464F4F;
    drv_ready = 1'b1;

    // Reset held two cycles with a word offered.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_out_valid", o_valid, 0);
      check("rst_out_char", o_char, 0);
      check("rst_out_last", o_last, 0);
      check("rst_out_empty", o_empty, 0);
      check("rst_in_ready", o_in_ready, 0);
    end
    rst_n     = 1'b1;
    drv_valid = 1'b0;
    tick();
    check("post_rst_in_ready", o_in_ready, 1);
    check("post_rst_out_valid", o_valid, 0);

    send(128'h464F4F, -1, 0, 1'b0);
    send(128'h0, -1, 0, 1'b0);
    send(128'h410042, -1, 0, 1'b0);
    w = "ABCDEFGHIJKLMNOP";
    send(w, 3, 5, 1'b0);

    // Reset during the second beat of "FOO".
    drv_data  = 128'h464F4F;
    drv_valid = 1'b1;
    drv_ready = 1'b1;
    tick();
    drv_valid = 1'b0;
    check("mid_beat1_char", o_char, 8'h46);
    tick();
    check("mid_beat2_char", o_char, 8'h4F);
    rst_n = 1'b0;
    tick();
    check("mid_rst_out_valid", o_valid, 0);
    check("mid_rst_in_ready", o_in_ready, 0);
    rst_n = 1'b1;
    tick();
    check("mid_release_in_ready", o_in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_more_beats", o_valid, 0);
    end
    send(128'h4849, -1, 0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      lead = $urandom_range(16);
      for (int b = 0; b < 16; b++) begin
        if (b >= 16 - lead || $urandom_range(3) == 0) w[b*8 +: 8] = 8'h00;
      end
      send(w, -1, 0, 1'b1);
    end

    sel = 1;
    tick();
    send(128'h464F4F, -1, 0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      lead = $urandom_range(16);
      for (int b = 16 - lead; b < 16; b++) w[b*8 +: 8] = 8'h00;
      send(w, -1, 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
